// File: rtl/dice_pkg.sv
// Shared constants and helpers for the BCD dice roller: die table, 7-segment
// decode and a BCD decrement with borrow across up to four digits.
package dice_pkg;

  localparam int unsigned MAX_BTN = 8;

  // Die faces per button, stored as 4-digit BCD so they load straight into the count.
  localparam logic [15:0] DIE_SIDES [MAX_BTN] = '{
    16'h0004, 16'h0006, 16'h0008, 16'h0010,
    16'h0012, 16'h0020, 16'h0100, 16'h0002
  };

  // Segments {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (borrow) begin
        if (v[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // A die is usable only if its face count fits in the available digits.
  function automatic logic die_fits(input logic [15:0] sides, input int unsigned ndig);
    return (sides >> (4 * ndig)) == 16'h0000;
  endfunction

endpackage

// File: rtl/dice_debounce.sv
// Single-bit tick-sampled debouncer: the output follows the input only after
// DEB_TICKS consecutive tick samples that all differ from the current output.
module dice_debounce #(
  parameter int unsigned DEB_TICKS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic in,
  output logic out
);

  localparam int unsigned CW = $clog2(DEB_TICKS + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;

  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (tick) begin
      if (in == out_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(DEB_TICKS - 1)) begin
        out_d = in;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/dice_roller_bcd.sv
// Parametrised BCD dice roller: debounced die buttons, wrap-to-max BCD count,
// release timeout and one-hot scanned 7-segment drive with leading-zero blanking.
module dice_roller_bcd
  import dice_pkg::*;
#(
  parameter int unsigned NDIG      = 3,
  parameter int unsigned NBTN      = 7,
  parameter int unsigned PRESC_W   = 10,
  parameter int unsigned DEB_TICKS = 3,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NBTN-1:0]   btn,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   dig_en,
  output logic [4*NDIG-1:0] value_bcd,
  output logic              rolling,
  output logic              valid
);

  localparam int unsigned VW = 4 * NDIG;
  localparam int unsigned SW = $clog2(NDIG);

  logic [PRESC_W-1:0] presc_q;
  logic               tick;
  logic [NBTN-1:0]    deb;
  logic [NBTN-1:0]    elig;
  logic               any;
  logic [2:0]         sel;
  logic               load;

  logic [VW-1:0]      value_q, value_d;
  logic [2:0]         die_sel_q, die_sel_d;
  logic               rolling_q;
  logic               valid_q, valid_d;
  logic [7:0]         timeout_q, timeout_d;
  logic [SW-1:0]      scan_q, scan_d;
  logic [6:0]         seg_q, seg_d;
  logic [NDIG-1:0]    dig_en_q, dig_en_d;

  logic               disp_on;
  logic [NDIG-1:0]    keep;
  logic               nz_above;
  logic [3:0]         digit;
  logic               shown;

  assign tick = (presc_q == '0);

  for (genvar i = 0; i < NBTN; i++) begin : g_deb
    dice_debounce #(
      .DEB_TICKS(DEB_TICKS)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .in   (btn[i]),
      .out  (deb[i])
    );
  end

  // Lowest-index eligible button wins.
  always_comb begin
    sel = 3'd0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      elig[i] = deb[i] && die_fits(DIE_SIDES[i], NDIG);
      if (elig[i]) sel = 3'(i);
    end
    any = |elig;
  end

  assign load = any && (!rolling_q || (sel != die_sel_q));

  always_comb begin
    value_d   = value_q;
    die_sel_d = die_sel_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;
    if (load) begin
      value_d   = VW'(DIE_SIDES[sel]);
      die_sel_d = sel;
      valid_d   = 1'b0;
    end else if (any) begin
      value_d = (value_q == VW'(1)) ? VW'(DIE_SIDES[die_sel_q]) : VW'(bcd_dec(16'(value_q)));
    end
    if (rolling_q && !any) begin
      valid_d   = 1'b1;
      timeout_d = 8'(TIMEOUT);
    end else if (tick && (timeout_q != 8'd0) && !any) begin
      timeout_d = timeout_q - 8'd1;
    end
  end

  assign disp_on = (timeout_q != 8'd0) && !any;

  // keep[k]: some digit at or above k is nonzero, so digit k is lit.
  always_comb begin
    keep     = '0;
    nz_above = 1'b0;
    for (int k = NDIG - 1; k >= 1; k--) begin
      nz_above = nz_above | (|value_q[4*k +: 4]);
      keep[k]  = nz_above;
    end
    keep[0] = 1'b1;
  end

  always_comb begin
    digit = 4'd0;
    shown = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (scan_q == SW'(k)) begin
        digit = value_q[4*k +: 4];
        shown = keep[k];
      end
    end
    scan_d   = (scan_q == SW'(NDIG - 1)) ? '0 : scan_q + 1'b1;
    seg_d    = seg_decode(digit);
    dig_en_d = (disp_on && shown) ? (NDIG'(1) << scan_q) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      value_q   <= VW'(1);
      die_sel_q <= 3'd0;
      rolling_q <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 8'd0;
      scan_q    <= '0;
      seg_q     <= 7'd0;
      dig_en_q  <= '0;
    end else begin
      presc_q   <= presc_q + 1'b1;
      value_q   <= value_d;
      die_sel_q <= die_sel_d;
      rolling_q <= any;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      scan_q    <= scan_d;
      seg_q     <= seg_d;
      dig_en_q  <= dig_en_d;
    end
  end

  assign seg       = seg_q;
  assign dig_en    = dig_en_q;
  assign value_bcd = value_q;
  assign rolling   = rolling_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_dice_roller_bcd.sv
// Directed bench for dice_roller_bcd: a 3-digit instance for counting and display,
// a 2-digit instance for range filtering and a short timeout.
module tb_dice_roller_bcd;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  btn_a = '0;
  logic [6:0]  btn_b = '0;
  logic [6:0]  seg_a, seg_b;
  logic [2:0]  dig_en_a;
  logic [1:0]  dig_en_b;
  logic [11:0] value_a;
  logic [7:0]  value_b;
  logic        rolling_a, rolling_b, valid_a, valid_b;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          edge_n  = 0;
  bit          last_tick;
  int          model_v   = 1;
  int          model_die = 1;
  logic [11:0] sb_q [$];
  logic [6:0]  seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  dice_roller_bcd #(
    .NDIG(3), .NBTN(7), .PRESC_W(2), .DEB_TICKS(3), .TIMEOUT(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .btn(btn_a), .seg(seg_a), .dig_en(dig_en_a),
    .value_bcd(value_a), .rolling(rolling_a), .valid(valid_a)
  );

  dice_roller_bcd #(
    .NDIG(2), .NBTN(7), .PRESC_W(2), .DEB_TICKS(3), .TIMEOUT(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .btn(btn_b), .seg(seg_b), .dig_en(dig_en_b),
    .value_bcd(value_b), .rolling(rolling_b), .valid(valid_b)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] bcd3(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // One clock; ticks land on every 4th edge after reset release (PRESC_W=2).
  task automatic step();
    bit was_tick = ((edge_n % 4) == 0);
    logic [11:0] exp;
    @(posedge clk);
    edge_n++;
    last_tick = was_tick;
    #1;
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      check("value_a", value_a, exp);
    end
  endtask

  task automatic advance(input bit counting);
    if (counting) model_v = (model_v == 1) ? model_die : model_v - 1;
    sb_q.push_back(bcd3(model_v));
    step();
  endtask

  task automatic run(input int ticks, input bit counting);
    int t = 0;
    int guard = 0;
    while (t < ticks && guard < 64) begin
      advance(counting);
      if (last_tick) t++;
      guard++;
    end
    if (t < ticks) check("tick_budget", t, ticks);
  endtask

  task automatic load(input int die);
    model_v   = die;
    model_die = die;
    sb_q.push_back(bcd3(model_v));
    step();
    check("rolling_after_load", rolling_a, 1'b1);
    check("valid_after_load", valid_a, 1'b0);
  endtask

  task automatic release_a();
    run(3, 1'b1);
    advance(1'b0);
    check("release_rolling", rolling_a, 1'b0);
    check("release_valid", valid_a, 1'b1);
  endtask

  // Per-edge display expectations on dut_a after a release, tracking the timeout.
  task automatic show_a(input int tleft_init, input int edges);
    int          tleft = tleft_init;
    int          d [3];
    int          top;
    int          s;
    logic [2:0]  en_exp;
    logic [6:0]  seg_exp;
    d[0] = model_v % 10;
    d[1] = (model_v / 10) % 10;
    d[2] = (model_v / 100) % 10;
    top  = (model_v >= 100) ? 2 : (model_v >= 10) ? 1 : 0;
    for (int e = 0; e < edges; e++) begin
      s       = edge_n % 3;
      en_exp  = (tleft != 0 && s <= top) ? (3'b001 << s) : 3'b000;
      seg_exp = seg_tab[d[s]];
      advance(1'b0);
      if (last_tick && tleft > 0) tleft--;
      check("dig_en_a", dig_en_a, en_exp);
      check("seg_a", seg_a, seg_exp);
    end
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    int tleft;
    int s;

    #12;
    check("rst_seg", seg_a, 7'h00);
    check("rst_dig_en", dig_en_a, 3'b000);
    check("rst_value", value_a, 12'h001);
    check("rst_rolling", rolling_a, 1'b0);
    check("rst_valid", valid_a, 1'b0);
    check("rst_value_b", value_b, 8'h01);
    reset_release();

    // Two-tick glitch must not load.
    btn_a[1] = 1'b1;
    run(2, 1'b0);
    btn_a[1] = 1'b0;
    run(2, 1'b0);
    check("glitch_rolling", rolling_a, 1'b0);
    check("glitch_value", value_a, 12'h001);

    // Three ticks held: debounced, load d6 on the next clock.
    btn_a[1] = 1'b1;
    run(3, 1'b0);
    check("pre_load_rolling", rolling_a, 1'b0);
    load(6);
    check("load_d6", value_a, 12'h006);
    btn_a[1] = 1'b0;
    release_a();

    // d20 wrap.
    btn_a[5] = 1'b1;
    run(3, 1'b0);
    load(20);
    for (int i = 1; i <= 25; i++) begin
      advance(1'b1);
      if (i == 20) check("wrap20", value_a, 12'h020);
    end

    // Reselect to d4, then back to d20.
    btn_a[0] = 1'b1;
    run(3, 1'b1);
    load(4);
    check("reselect_d4", value_a, 12'h004);
    repeat (5) advance(1'b1);
    btn_a[0] = 1'b0;
    run(3, 1'b1);
    load(20);
    check("reload_d20", value_a, 12'h020);
    btn_a[5] = 1'b0;
    release_a();
    show_a(4, 20);

    // d100 rolled down to a single digit before release.
    btn_a[6] = 1'b1;
    run(3, 1'b0);
    load(100);
    while (model_v > 18) advance(1'b1);
    btn_a[6] = 1'b0;
    release_a();
    show_a(4, 20);

    // Asynchronous reset mid-scan.
    btn_a[3] = 1'b1;
    run(3, 1'b0);
    load(10);
    btn_a[3] = 1'b0;
    release_a();
    show_a(4, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_seg", seg_a, 7'h00);
    check("arst_dig_en", dig_en_a, 3'b000);
    check("arst_value", value_a, 12'h001);
    check("arst_valid", valid_a, 1'b0);
    check("arst_rolling", rolling_a, 1'b0);
    sb_q.delete();
    model_v   = 1;
    model_die = 1;
    reset_release();
    advance(1'b0);
    check("post_rst_dig_en", dig_en_a, 3'b000);

    // Two digits: d100 is ignored, d4 loads, short timeout blanks the display.
    btn_b = 7'h40;
    run(4, 1'b0);
    check("range_rolling_b", rolling_b, 1'b0);
    check("range_value_b", value_b, 8'h01);
    btn_b = 7'h41;
    run(3, 1'b0);
    advance(1'b0);
    check("load_rolling_b", rolling_b, 1'b1);
    check("load_value_b", value_b, 8'h04);
    btn_b = 7'h00;
    run(3, 1'b0);
    advance(1'b0);
    check("release_rolling_b", rolling_b, 1'b0);
    check("release_valid_b", valid_b, 1'b1);
    check("release_value_b", value_b, 8'h01);
    tleft = 2;
    for (int e = 0; e < 12; e++) begin
      s = edge_n % 2;
      advance(1'b0);
      check("dig_en_b", dig_en_b, (tleft != 0 && s == 0) ? 2'b01 : 2'b00);
      if (last_tick && tleft > 0) tleft--;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
